// File: rtl/dmem_responder.sv
// Data-memory slave for the pipeline master bus: word RAM plus an MMIO window
// holding the run result/done flag, a free-running cycle counter and a RAM-write counter.
module dmem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_sel,
  input  logic        m_rnw,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_data,
  output logic [31:0] s_data,
  input  logic [31:0] dbg_addr,
  output logic [31:0] dbg_data,
  output logic [31:0] result,
  output logic        done,
  output logic        err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [15:0] OffResult = 16'h0000;
  localparam logic [15:0] OffCycle  = 16'h0004;
  localparam logic [15:0] OffWrcnt  = 16'h0008;

  logic [31:0] mem [DEPTH];

  logic [31:0] s_data_q, s_data_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] cycle_q;
  logic [31:0] wrcnt_q, wrcnt_d;

  // Address decode
  logic [29:0]   word_idx;
  logic [AW-1:0] ram_idx;
  logic [15:0]   mmio_off;
  logic          is_mmio;
  logic          misaligned;
  logic          out_of_range;
  logic          bus_err;
  logic          ram_we;
  logic          result_we;

  assign word_idx     = m_addr[31:2];
  assign ram_idx      = m_addr[AW+1:2];
  assign mmio_off     = m_addr[15:0];
  assign is_mmio      = (m_addr[31:16] == MMIO_BASE[31:16]);
  assign misaligned   = (m_addr[1:0] != 2'b00);
  assign out_of_range = !is_mmio && ({2'b00, word_idx} >= DEPTH);
  assign bus_err      = m_sel && (misaligned || out_of_range);
  assign ram_we       = m_sel && !m_rnw && !is_mmio && !bus_err;
  assign result_we    = m_sel && !m_rnw && is_mmio && !bus_err && (mmio_off == OffResult);

  // Read data sources
  logic [31:0] ram_rdata;
  logic [31:0] mmio_rdata;

  assign ram_rdata = mem[ram_idx];

  always_comb begin
    mmio_rdata = '0;
    unique case (mmio_off)
      OffResult: mmio_rdata = result_q;
      OffCycle:  mmio_rdata = cycle_q;
      OffWrcnt:  mmio_rdata = wrcnt_q;
      default:   mmio_rdata = '0;
    endcase
  end

  // Next-state logic for the bus-visible registers
  always_comb begin
    s_data_d = s_data_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;
    wrcnt_d  = wrcnt_q;

    if (bus_err) begin
      err_d = 1'b1;
    end

    if (m_sel && m_rnw) begin
      if (bus_err) begin
        s_data_d = '0;
      end else if (is_mmio) begin
        s_data_d = mmio_rdata;
      end else begin
        s_data_d = ram_rdata;
      end
    end

    if (result_we) begin
      result_d = m_data;
      done_d   = 1'b1;
    end

    if (ram_we && (wrcnt_q != 32'hFFFF_FFFF)) begin
      wrcnt_d = wrcnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_data_q <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cycle_q  <= '0;
      wrcnt_q  <= '0;
    end else begin
      s_data_q <= s_data_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cycle_q  <= cycle_q + 32'd1;
      wrcnt_q  <= wrcnt_d;
    end
  end

  // RAM contents survive reset so a run can be inspected after it is stopped
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= m_data;
    end
  end

  logic dbg_in_range;

  assign dbg_in_range = (dbg_addr < DEPTH);
  assign dbg_data     = dbg_in_range ? mem[dbg_addr[AW-1:0]] : '0;

  assign s_data = s_data_q;
  assign result = result_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scenario bench for dmem_responder: read expectations are queued when a read is driven
// and popped when s_data is due one cycle later.
module tb_dmem_responder;

  localparam logic [31:0] Base = 32'hFFFF_0000;

  logic        clk;
  logic        rst_n;
  logic        m_sel;
  logic        m_rnw;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic [31:0] s_data;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_data;
  logic [31:0] result;
  logic        done;
  logic        err;

  int n_checks;
  int n_err;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  logic [31:0] c1;
  logic [31:0] c2;

  dmem_responder #(
    .DEPTH    (1024),
    .MMIO_BASE(Base)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m_sel   (m_sel),
    .m_rnw   (m_rnw),
    .m_addr  (m_addr),
    .m_data  (m_data),
    .s_data  (s_data),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data),
    .result  (result),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge, so outputs are stable when sampled there.
  task automatic drive(input logic sel, input logic rnw, input logic [31:0] addr,
                       input logic [31:0] data);
    @(negedge clk);
    m_sel  = sel;
    m_rnw  = rnw;
    m_addr = addr;
    m_data = data;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 32'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    drive(1'b1, 1'b0, addr, data);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] expv);
    drive(1'b1, 1'b1, addr, 32'h0);
    exp_q.push_back(expv);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_sel = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    m_sel    = 1'b0;
    m_rnw    = 1'b1;
    m_addr   = '0;
    m_data   = '0;
    dbg_addr = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({s_data, result, done, err} !== {64'h0, 2'b00}) begin
      n_err++;
      $display("FAIL reset_state: got s_data=%h result=%h done=%b err=%b want all zero",
               s_data, result, done, err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ram_rw();
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, 32'hDEAD_BEEF);
    dbg_addr = 32'd4;
    idle();
    e = exp_q.pop_front();
    n_checks++;
    if (s_data !== e) begin
      n_err++;
      $display("FAIL ram_read: got %h want %h", s_data, e);
    end
    n_checks++;
    if (dbg_data !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL dbg_read: got %h want %h", dbg_data, 32'hDEAD_BEEF);
    end
    rd(Base + 32'h8, 32'd1);
    idle();
    e = exp_q.pop_front();
    n_checks++;
    if (s_data !== e) begin
      n_err++;
      $display("FAIL wrcnt_one: got %h want %h", s_data, e);
    end
  endtask

  task automatic test_back_to_back();
    wr(32'h20, 32'h55);
    rd(32'h20, 32'h55);
    idle();
    e = exp_q.pop_front();
    n_checks++;
    if (s_data !== e) begin
      n_err++;
      $display("FAIL raw_b2b: got %h want %h", s_data, e);
    end
    repeat (3) idle();
    n_checks++;
    if (s_data !== 32'h55) begin
      n_err++;
      $display("FAIL s_data_hold: got %h want %h", s_data, 32'h55);
    end
    // dbg_data reflects a write only after the edge that performs it
    wr(32'h24, 32'hAAAA_0001);
    dbg_addr = 32'd9;
    wr(32'h24, 32'hBBBB_0002);
    #1;
    n_checks++;
    if (dbg_data !== 32'hAAAA_0001) begin
      n_err++;
      $display("FAIL dbg_before_edge: got %h want %h", dbg_data, 32'hAAAA_0001);
    end
    idle();
    n_checks++;
    if (dbg_data !== 32'hBBBB_0002) begin
      n_err++;
      $display("FAIL dbg_after_edge: got %h want %h", dbg_data, 32'hBBBB_0002);
    end
  endtask

  task automatic test_bus_err();
    wr(32'h0, 32'h1111_2222);
    idle();
    n_checks++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clean: got %b want 0", err);
    end
    wr(32'h22, 32'hBAD0_0001);
    idle();
    n_checks++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL err_misaligned: got %b want 1", err);
    end
    dbg_addr = 32'd8;
    #1;
    n_checks++;
    if (dbg_data !== 32'h55) begin
      n_err++;
      $display("FAIL misaligned_dropped: got %h want %h", dbg_data, 32'h55);
    end
    wr(32'h1000, 32'hBAD0_0002);
    rd(32'h1000, 32'h0);
    idle();
    e = exp_q.pop_front();
    n_checks++;
    if (s_data !== e) begin
      n_err++;
      $display("FAIL oor_read: got %h want %h", s_data, e);
    end
    rd(32'h1E, 32'h0);
    idle();
    e = exp_q.pop_front();
    n_checks++;
    if (s_data !== e) begin
      n_err++;
      $display("FAIL misaligned_read: got %h want %h", s_data, e);
    end
    // Accepted writes so far: 0x10, 0x20, 0x24 twice, 0x0
    rd(Base + 32'h8, 32'd5);
    idle();
    e = exp_q.pop_front();
    n_checks++;
    if (s_data !== e) begin
      n_err++;
      $display("FAIL wrcnt_after_err: got %h want %h", s_data, e);
    end
    dbg_addr = 32'd0;
    #1;
    n_checks++;
    if (dbg_data !== 32'h1111_2222) begin
      n_err++;
      $display("FAIL ram0_intact: got %h want %h", dbg_data, 32'h1111_2222);
    end
    dbg_addr = 32'd1024;
    #1;
    n_checks++;
    if (dbg_data !== 32'h0) begin
      n_err++;
      $display("FAIL dbg_oor: got %h want 0", dbg_data);
    end
    n_checks++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL err_sticky: got %b want 1", err);
    end
  endtask

  task automatic test_mmio_result();
    wr(Base, 32'd45);
    idle();
    n_checks++;
    if ({result, done} !== {32'd45, 1'b1}) begin
      n_err++;
      $display("FAIL result_first: got result=%0d done=%b want 45 1", result, done);
    end
    wr(Base, 32'd7);
    idle();
    n_checks++;
    if ({result, done} !== {32'd7, 1'b1}) begin
      n_err++;
      $display("FAIL result_overwrite: got result=%0d done=%b want 7 1", result, done);
    end
    rd(Base, 32'd7);
    idle();
    e = exp_q.pop_front();
    n_checks++;
    if (s_data !== e) begin
      n_err++;
      $display("FAIL result_read: got %h want %h", s_data, e);
    end
  endtask

  task automatic test_mid_reset();
    rd(32'h10, 32'hDEAD_BEEF);
    idle();
    e = exp_q.pop_front();
    n_checks++;
    if (s_data !== e) begin
      n_err++;
      $display("FAIL pre_reset_read: got %h want %h", s_data, e);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_data, result, done, err} !== {64'h0, 2'b00}) begin
      n_err++;
      $display("FAIL async_reset: got s_data=%h result=%h done=%b err=%b want all zero",
               s_data, result, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rd(32'h10, 32'hDEAD_BEEF);
    idle();
    e = exp_q.pop_front();
    n_checks++;
    if (s_data !== e) begin
      n_err++;
      $display("FAIL ram_retained_10: got %h want %h", s_data, e);
    end
    rd(32'h20, 32'h55);
    idle();
    e = exp_q.pop_front();
    n_checks++;
    if (s_data !== e) begin
      n_err++;
      $display("FAIL ram_retained_20: got %h want %h", s_data, e);
    end
    rd(Base + 32'h8, 32'd0);
    idle();
    e = exp_q.pop_front();
    n_checks++;
    if (s_data !== e) begin
      n_err++;
      $display("FAIL wrcnt_cleared: got %h want %h", s_data, e);
    end
  endtask

  task automatic test_cycle();
    // A read sampled on the k-th rising edge after release returns k-1.
    do_reset();
    repeat (9) idle();
    rd(Base + 32'h4, 32'd10);
    idle();
    e = exp_q.pop_front();
    c1 = s_data;
    n_checks++;
    if (s_data !== e) begin
      n_err++;
      $display("FAIL cycle_10: got %0d want %0d", s_data, e);
    end
    repeat (8) idle();
    rd(Base + 32'h4, 32'd20);
    idle();
    e = exp_q.pop_front();
    c2 = s_data;
    n_checks++;
    if (s_data !== e) begin
      n_err++;
      $display("FAIL cycle_20: got %0d want %0d", s_data, e);
    end
    n_checks++;
    if (c2 - c1 !== 32'd10) begin
      n_err++;
      $display("FAIL cycle_delta: got %0d want 10", c2 - c1);
    end
    wr(Base + 32'h4, 32'h1234_5678);
    wr(Base + 32'h8, 32'h1234_5678);
    rd(Base + 32'h10, 32'h0);
    idle();
    e = exp_q.pop_front();
    n_checks++;
    if (s_data !== e) begin
      n_err++;
      $display("FAIL unmapped_read: got %h want %h", s_data, e);
    end
    n_checks++;
    if ({err, done} !== 2'b00) begin
      n_err++;
      $display("FAIL ro_write_ignored: got err=%b done=%b want 0 0", err, done);
    end
    wr(Base + 32'h2, 32'h99);
    idle();
    n_checks++;
    if ({err, done, result} !== {2'b10, 32'h0}) begin
      n_err++;
      $display("FAIL mmio_misaligned: got err=%b done=%b result=%h want 1 0 0",
               err, done, result);
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    test_reset();
    test_ram_rw();
    test_back_to_back();
    test_bus_err();
    test_mmio_result();
    test_mid_reset();
    test_cycle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave on the pipeline's m_* master bus (m_sel/m_rnw/m_addr/m_data); returns read data on s_data.
- Word-addressed RAM plus a small MMIO window: result/done register, free-running cycle counter, RAM-write counter.
- Benches and FPGA top use done/result to terminate a run.
- Side debug read port lets the bench inspect RAM without touching the bus.

Parameters:
DEPTH, 1024, number of 32-bit RAM words; power of two
MMIO_BASE, 32'hFFFF_0000, byte base address of the MMIO window (64 KiB aligned)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
m_sel  input  1  bus transaction request, one transaction per cycle
m_rnw  input  1  1 = read, 0 = write
m_addr  input  32  byte address
m_data  input  32  write data
s_data  output  32  read data, registered
dbg_addr  input  32  RAM word index for debug read
dbg_data  output  32  combinational RAM[dbg_addr]; 0 if out of range
result  output  32  last value written to MMIO RESULT
done  output  1  sticky; set by any write to RESULT
err  output  1  sticky bus-error flag

Behaviour:
- Reset (async, rst_n=0) sets s_data=0, result=0, done=0, err=0, CYCLE=0, WRCNT=0. RAM contents are not cleared.
- Decode on each rising edge with m_sel=1:
  - m_addr[31:16]==MMIO_BASE[31:16] selects MMIO.
  - Otherwise RAM, word index m_addr[31:2].
- RAM write (m_rnw=0):
  - RAM[m_addr[31:2]] <= m_data.
  - WRCNT increments, saturating at 32'hFFFF_FFFF.
- Read (m_rnw=1): s_data <= selected data at the same edge, so the value is visible the cycle after the request (latency 1). s_data holds its value until the next read.
- Read-after-write, same address, back-to-back cycles: the read returns the newly written data, with no stale value.
- Bus error: misaligned access (m_addr[1:0]!=0) or RAM word index >= DEPTH.
  - err <= 1 (sticky until reset).
  - Writes are dropped and WRCNT is unchanged.
  - Reads set s_data <= 0.
- MMIO map (offsets from MMIO_BASE):
  - 0x0 RESULT, RW: a write sets result <= m_data and done <= 1; a read returns result.
  - 0x4 CYCLE, RO: free-running count of cycles since reset; wraps 32'hFFFF_FFFF -> 0.
  - 0x8 WRCNT, RO: saturating count of accepted RAM writes.
  - Writes to RO registers are ignored without err.
  - Reads of other in-window offsets return 0 without err.
  - Misaligned MMIO access sets err.
- Repeated RESULT writes overwrite result; done stays 1.
- m_sel=0: no state change except CYCLE; s_data holds.
- dbg_data is purely combinational and independent of bus activity.
  - The same-cycle write is visible on dbg_data only after the edge.
- Reset asserted mid-run: all registers clear immediately; RAM is retained; CYCLE restarts from 0 after release.

Test Plan:
- Reset then write 32'hDEADBEEF to addr 0x10, read 0x10 next cycle -> s_data=32'hDEADBEEF one cycle after the read request; dbg_addr=4 gives dbg_data=32'hDEADBEEF; WRCNT read = 1.
- Write 0x55 to 0x20 in cycle N, read 0x20 in cycle N+1 -> s_data=0x55 in cycle N+2; m_sel=0 afterwards -> s_data stays 0x55.
- Write to 0x22 (misaligned) and to 0x1000 (index 1024, out of range) -> err=1; read 0x1000 returns 0; WRCNT unchanged; RAM[0] unchanged.
- Write 45 to MMIO_BASE+0x0 -> result=45 and done=1 the following cycle; then write 7 -> result=7, done stays 1; read RESULT -> 7.
- Read CYCLE at reset-release cycle +10 and +20 -> difference exactly 10; write to CYCLE -> ignored, err stays 0.
- Assert rst_n=0 mid-run with done=1, err=1 -> both 0 asynchronously, s_data=0; previously written RAM words still read back intact after release.
